// File: rtl/reg_bank_uart_host_if.sv
// Host-side request/response bundle for the register-bank UART initiator.
// The master drives a request; the slave (the UART host engine) answers with
// busy/done and the response byte.
interface reg_bank_uart_host_if;
  logic       req_in;
  logic       we_in;
  logic [6:0] addr_in;
  logic [7:0] wdata_in;
  logic       busy_out;
  logic       done_out;
  logic [7:0] rdata_out;
  logic       err_out;

  modport master (
    output req_in, we_in, addr_in, wdata_in,
    input  busy_out, done_out, rdata_out, err_out
  );

  modport slave (
    input  req_in, we_in, addr_in, wdata_in,
    output busy_out, done_out, rdata_out, err_out
  );
endinterface

// File: rtl/reg_bank_uart_host.sv
// UART command initiator for the register bank serial port.
// Turns one parallel read/write request into an 8N1 command frame (plus a data
// frame for writes), then waits for the single response byte on rx_in and
// reports it with a done pulse and an error flag.
module reg_bank_uart_host #(
  parameter int CLKS_PER_BIT = 142,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  reg_bank_uart_host_if.slave        bus,
  output logic                       tx_out,
  input  logic                       rx_in
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int TOUT_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BIT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]        LAST_SLOT = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_DATA,
    WAIT_RESP,
    RX_BYTE,
    FINISH
  } state_t;

  state_t             state;
  logic               we_q;
  logic [7:0]         wdata_q;
  logic [9:0]         tx_sr;
  logic               tx_q;
  logic [CNT_W-1:0]   clk_cnt;
  logic [3:0]         bit_idx;
  logic [TOUT_W-1:0]  tout_cnt;
  logic [7:0]         rx_sr;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [7:0]         rdata_q;

  logic               rx_s1;
  logic               rx_s2;
  logic               rx_prev;
  logic               rx_fall;

  // 10-bit 8N1 frame, LSB transmitted first: start(0), data[0..7], stop(1).
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Response is bad if the stop bit reads low, or a write echo differs.
  function automatic logic resp_err(input logic       stop_bit,
                                    input logic       is_write,
                                    input logic [7:0] rx_byte,
                                    input logic [7:0] sent_byte);
    return (~stop_bit) | (is_write & (rx_byte != sent_byte));
  endfunction

  // Two-flop synchronizer for the asynchronous rx line plus one delay for edge detect.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  // Transaction FSM: serialize command/data, await response, deserialize, report.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 8'h00;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      tout_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // A request coinciding with the done pulse is deliberately dropped.
          if (bus.req_in && !done_q) begin
            we_q    <= bus.we_in;
            wdata_q <= bus.wdata_in;
            tx_sr   <= frame_of({bus.we_in, bus.addr_in});
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= TX_CMD;
          end
        end

        TX_CMD, TX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_SLOT) begin
              bit_idx <= '0;
              if (state == TX_CMD && we_q) begin
                // Data frame follows the command stop bit with no idle gap.
                tx_sr <= frame_of(wdata_q);
                tx_q  <= 1'b0;
                state <= TX_DATA;
              end else begin
                tx_q     <= 1'b1;
                tout_cnt <= '0;
                state    <= WAIT_RESP;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx_q    <= tx_sr[1];
              tx_sr   <= {1'b1, tx_sr[9:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        WAIT_RESP: begin
          if (rx_fall) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            tout_cnt <= tout_cnt + 1'b1;
            state    <= RX_BYTE;
          end else if (tout_cnt >= TOUT_LAST) begin
            // Silent responder: flag the error, keep the previous rdata.
            err_q <= 1'b1;
            state <= FINISH;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end

        RX_BYTE: begin
          if (bit_idx == 4'd0) begin
            // Timeout keeps running until the start bit is confirmed.
            tout_cnt <= tout_cnt + 1'b1;
            if (clk_cnt == BIT_HALF) begin
              clk_cnt <= '0;
              if (rx_s2) begin
                state <= WAIT_RESP;
              end else begin
                bit_idx <= 4'd1;
              end
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end else if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_SLOT) begin
              // Stop-bit sample taken: finish without waiting out the stop bit.
              rdata_q <= rx_sr;
              err_q   <= resp_err(rx_s2, we_q, rx_sr, wdata_q);
              state   <= FINISH;
            end else begin
              rx_sr   <= {rx_s2, rx_sr[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign tx_out        = tx_q;
  assign bus.busy_out  = busy_q;
  assign bus.done_out  = done_q;
  assign bus.rdata_out = rdata_q;
  assign bus.err_out   = err_q;

endmodule

// File: tb/tb_reg_bank_uart_host.sv
// Bench for reg_bank_uart_host: directed transactions, a tx-line decoder and a
// done monitor that pop expected results pushed by the stimulus.
module tb_reg_bank_uart_host;

  localparam int CPB  = 142;
  localparam int TOUT = 4096;

  logic clk = 1'b0;
  logic rst;
  logic tx_line;
  logic rx_line;

  reg_bank_uart_host_if bus();

  reg_bank_uart_host #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TOUT)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus),
    .tx_out (tx_line),
    .rx_in  (rx_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         gap;
  } tx_exp_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    bit         chk_time;
  } done_exp_t;

  tx_exp_t     exp_tx_q[$];
  done_exp_t   exp_done_q[$];

  int unsigned cyc = 0;
  int unsigned stop_end = 0;
  int unsigned last_t0 = 0;
  int          frames_seen = 0;
  int          done_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          tx_ignore = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_tx(input logic [7:0] b, input bit gap);
    tx_exp_t e;
    e.b = b;
    e.gap = gap;
    exp_tx_q.push_back(e);
  endtask

  task automatic push_done(input logic [7:0] r, input logic e, input bit t);
    done_exp_t d;
    d.rdata = r;
    d.err = e;
    d.chk_time = t;
    exp_done_q.push_back(d);
  endtask

  // tx decoder: samples each bit at its middle and checks against expectations
  initial begin : tx_mon
    logic [7:0]  b;
    logic        st;
    logic        sp;
    int unsigned t0;
    tx_exp_t     e;
    forever begin
      @(negedge clk);
      if (!rst && tx_line === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        st = tx_line;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_line;
        end
        repeat (CPB) @(negedge clk);
        sp = tx_line;
        if (!tx_ignore) begin
          if (exp_tx_q.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected: got frame 0x%0h, expected no frame", b);
          end else begin
            e = exp_tx_q.pop_front();
            chk("tx_byte", {24'd0, b}, {24'd0, e.b});
            chk("tx_start_bit", {31'd0, st}, 32'd0);
            chk("tx_stop_bit", {31'd0, sp}, 32'd1);
            if (e.gap) chk("tx_back_to_back", t0 - last_t0, 10 * CPB);
          end
        end
        last_t0 = t0;
        stop_end = t0 + 10 * CPB;
        frames_seen++;
      end
    end
  end

  // done monitor: pops the expected result for each done pulse
  initial begin : done_mon
    done_exp_t   d;
    int unsigned lat;
    forever begin
      @(negedge clk);
      if (bus.done_out === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done with rdata 0x%0h, expected no done", bus.rdata_out);
        end else begin
          d = exp_done_q.pop_front();
          chk("rdata", {24'd0, bus.rdata_out}, {24'd0, d.rdata});
          chk("err", {31'd0, bus.err_out}, {31'd0, d.err});
          chk("busy_at_done", {31'd0, bus.busy_out}, 32'd0);
          if (d.chk_time) begin
            lat = cyc - stop_end;
            n_checks++;
            if (lat >= TOUT - 2 && lat <= TOUT + 2) n_pass++;
            else $display("FAIL timeout_latency: got %0d clocks, expected %0d +/-2", lat, TOUT);
          end
        end
        done_count++;
      end
    end
  end

  task automatic do_req(input logic we, input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.req_in = 1'b1;
    bus.we_in = we;
    bus.addr_in = a;
    bus.wdata_in = d;
    @(posedge clk); #1;
    bus.req_in = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx_line = stop;
    repeat (CPB) @(posedge clk);
    rx_line = 1'b1;
  endtask

  // mode: 0 silent responder, 1 plain response, 2 glitch then response
  task automatic txn(input logic we, input logic [6:0] a, input logic [7:0] d,
                     input int mode, input logic [7:0] resp, input logic stop,
                     input int delay, input logic [7:0] exp_r, input logic exp_e,
                     input bit extra_req);
    int base;
    int start_dc;
    int k;
    base = frames_seen;
    start_dc = done_count;
    push_tx({we, a}, 1'b0);
    if (we) push_tx(d, 1'b1);
    push_done(exp_r, exp_e, mode == 0);
    do_req(we, a, d);
    chk("busy_after_accept", {31'd0, bus.busy_out}, 32'd1);
    if (extra_req) begin
      repeat (100) @(posedge clk); #1;
      bus.req_in = 1'b1;
      bus.we_in = 1'b1;
      bus.addr_in = 7'h7F;
      bus.wdata_in = 8'h00;
      @(posedge clk); #1;
      bus.req_in = 1'b0;
    end
    k = 0;
    while (frames_seen < base + (we ? 2 : 1) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (frames_seen < base + (we ? 2 : 1)) begin
      n_checks++;
      $display("FAIL tx_frames_wait: got %0d frames, expected %0d", frames_seen - base, we ? 2 : 1);
    end
    if (mode != 0) begin
      while (cyc < stop_end + delay) @(posedge clk);
      #1;
      if (mode == 2) begin
        rx_line = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (200) @(posedge clk);
        #1;
      end
      send_rx(resp, stop);
    end
    k = 0;
    while (done_count == start_dc && k < 8000) begin
      @(posedge clk);
      k++;
    end
    if (done_count == start_dc) begin
      n_checks++;
      $display("FAIL done_wait: got no done within 8000 clocks, expected one");
    end
    repeat (20) @(posedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 clocks");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int dc;
    rst = 1'b1;
    rx_line = 1'b1;
    bus.req_in = 1'b0;
    bus.we_in = 1'b0;
    bus.addr_in = 7'h00;
    bus.wdata_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {31'd0, tx_line}, 32'd1);
    chk("reset_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("reset_done", {31'd0, bus.done_out}, 32'd0);
    chk("reset_err", {31'd0, bus.err_out}, 32'd0);
    chk("reset_rdata", {24'd0, bus.rdata_out}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // write 0x3C to 0x05, echoed
    txn(1'b1, 7'h05, 8'h3C, 1, 8'h3C, 1'b1, 10, 8'h3C, 1'b0, 1'b0);
    // read 0x02, responder answers 0xA7 ~300 clocks after the stop bit
    txn(1'b0, 7'h02, 8'h00, 1, 8'hA7, 1'b1, 300, 8'hA7, 1'b0, 1'b0);
    // read 0x03, silent responder: timeout, rdata keeps 0xA7
    txn(1'b0, 7'h03, 8'h00, 0, 8'h00, 1'b1, 0, 8'hA7, 1'b1, 1'b0);
    // write 0x11 to 0x01, echo comes back as 0x10
    txn(1'b1, 7'h01, 8'h11, 1, 8'h10, 1'b1, 50, 8'h10, 1'b1, 1'b0);
    // read 0x04, response with a low stop bit
    txn(1'b0, 7'h04, 8'h00, 1, 8'h66, 1'b0, 100, 8'h66, 1'b1, 1'b0);
    // read 0x06, 20-clock glitch then a valid 0x5A
    txn(1'b0, 7'h06, 8'h00, 2, 8'h5A, 1'b1, 50, 8'h5A, 1'b0, 1'b0);
    // read 0x07 with a second request pulsed while busy
    txn(1'b0, 7'h07, 8'h00, 1, 8'h3E, 1'b1, 80, 8'h3E, 1'b0, 1'b1);

    // reset halfway through a command frame
    tx_ignore = 1'b1;
    dc = done_count;
    do_req(1'b1, 7'h10, 8'h55);
    repeat (10 * CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_tx_idle", {31'd0, tx_line}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy_out}, 32'd0);
    repeat (3000) @(posedge clk);
    chk("abort_no_done", done_count, dc);
    tx_ignore = 1'b0;

    // recovery read after the abort
    txn(1'b0, 7'h09, 8'h00, 1, 8'hC3, 1'b1, 40, 8'hC3, 1'b0, 1'b0);

    repeat (3000) @(posedge clk);
    chk("tx_queue_empty", exp_tx_q.size(), 32'd0);
    chk("done_queue_empty", exp_done_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
